arbitro_mux_forzado: RTL and testbench

ARBITRO_MUX_FORZADO -- requirements
Module: arbitro_mux_forzado

---
 rtl/arbitro_mux_forzado_pkg.sv | 20 ++
 rtl/arbitro_mux_forzado_rr_selector.sv | 31 +++
 rtl/arbitro_mux_forzado.sv | 161 ++++++++++++++++
 tb/tb_arbitro_mux_forzado.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/arbitro_mux_forzado_pkg.sv
// Shared definitions for the arbitro_mux_forzado forced-mux arbiter:
// FSM state encoding, CONTROL select width and the default lane count.
package arbitro_mux_forzado_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_FORCED = 2'd2
    } state_t;

    // Width of CONTROL / FORCE_SEL
    localparam int CTRL_W = 4;

    // Number of selectable indices addressable by CONTROL
    localparam int SEL_SPAN = 1 << CTRL_W;

    // Default number of requesting lanes
    localparam int DEF_NUM_LANES = 10;

endpackage

// File: rtl/arbitro_mux_forzado_rr_selector.sv
// Combinational round-robin next-lane finder: returns the first set request
// bit strictly after the pointer, wrapping from NUM_LANES-1 back to 0. The
// pointer lane itself is the last candidate examined.
module rr_selector
    import arbitro_mux_forzado_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES
) (
    input  logic [NUM_LANES-1:0] i_req,
    input  logic [CTRL_W-1:0]    i_ptr,
    output logic                 o_found,
    output logic [CTRL_W-1:0]    o_idx
);

    int w_j;

    // Scan farthest candidate first so the nearest requester overwrites it
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            w_j = (int'(i_ptr) + k) % NUM_LANES;
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = CTRL_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/arbitro_mux_forzado.sv
// Round-robin burst arbiter driving a forced mux select.
// Lanes are granted for up to BURST_LEN consecutive cycles; FORCE_EN overrides
// arbitration and steers CONTROL straight from FORCE_SEL.
// Optional build macro: ARB_FORCE_TIMEOUT_EN -- limits a forced episode to
// FORCE_MAX cycles, pulses ERR_FORCE on expiry and blocks re-entry until
// FORCE_EN has been seen low.
module arbitro_mux_forzado
    import arbitro_mux_forzado_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int BURST_LEN = 4,
    parameter int FORCE_MAX = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_L,
    input  logic [NUM_LANES-1:0] REQ,
    input  logic                 FORCE_EN,
    input  logic [CTRL_W-1:0]    FORCE_SEL,
    output logic [CTRL_W-1:0]    CONTROL,
    output logic                 VALID,
    output logic [NUM_LANES-1:0] GRANT,
    output logic                 ERR_FORCE
);

    state_t                 r_state;
    logic [CTRL_W-1:0]      r_ctrl;
    logic                   r_valid;
    logic [NUM_LANES-1:0]   r_grant;
    logic                   r_err;
    logic [CTRL_W-1:0]      r_ptr;
    logic [3:0]             r_cnt;

    logic                   w_found;
    logic [CTRL_W-1:0]      w_idx;
    logic [SEL_SPAN-1:0]    w_req_pad;
    logic [NUM_LANES-1:0]   w_win_onehot;
    logic [NUM_LANES-1:0]   w_force_onehot;
    logic                   w_sel_ok;
    logic                   w_sel_req;
    logic                   w_rearb;
    logic                   w_force_go;

    rr_selector #(
        .NUM_LANES (NUM_LANES)
    ) u_rr_selector (
        .i_req   (REQ),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // Zero-padded request vector so any 4-bit index can be looked up safely
    assign w_req_pad      = SEL_SPAN'(REQ);
    assign w_win_onehot   = NUM_LANES'(1) << w_idx;
    assign w_sel_ok       = int'(FORCE_SEL) < NUM_LANES;
    assign w_sel_req      = w_req_pad[FORCE_SEL];
    assign w_force_onehot = (w_sel_ok && w_sel_req) ? (NUM_LANES'(1) << FORCE_SEL) : '0;
    assign w_rearb        = (r_cnt == 4'(BURST_LEN)) || !w_req_pad[r_ctrl];

`ifdef ARB_FORCE_TIMEOUT_EN
    localparam int TW = $clog2(FORCE_MAX + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_block;
    logic          w_timeout;

    assign w_force_go = FORCE_EN && !r_block;
    assign w_timeout  = (r_state == ST_FORCED) && (r_tcnt == TW'(FORCE_MAX));

    // Forced-episode length counter and re-entry lockout after a timeout
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_tcnt  <= '0;
            r_block <= 1'b0;
        end else begin
            if (w_force_go && !w_timeout) begin
                r_tcnt <= (r_state == ST_FORCED) ? r_tcnt + 1'b1 : TW'(1);
            end else begin
                r_tcnt <= '0;
            end
            if (w_force_go && w_timeout) begin
                r_block <= 1'b1;
            end else if (!FORCE_EN) begin
                r_block <= 1'b0;
            end
        end
    end
`else
    logic w_timeout;

    assign w_force_go = FORCE_EN;
    assign w_timeout  = 1'b0;

    // FORCE_MAX only shapes the timeout build; nothing to generate here
    if (FORCE_MAX < 1) begin : g_no_timeout
    end
`endif

    // Arbitration FSM with all outputs registered
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state <= ST_IDLE;
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_err   <= 1'b0;
            r_ptr   <= CTRL_W'(NUM_LANES - 1);
            r_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_force_go && w_timeout) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_grant <= '0;
                r_err   <= 1'b1;
                r_cnt   <= '0;
            end else if (w_force_go) begin
                r_state <= ST_FORCED;
                r_ctrl  <= FORCE_SEL;
                r_valid <= w_sel_ok && w_sel_req;
                r_grant <= w_force_onehot;
                r_err   <= !w_sel_ok;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_GRANT: begin
                        if ((r_state == ST_IDLE) || w_rearb) begin
                            if (w_found) begin
                                r_state <= ST_GRANT;
                                r_ctrl  <= w_idx;
                                r_valid <= 1'b1;
                                r_grant <= w_win_onehot;
                                r_ptr   <= w_idx;
                                r_cnt   <= 4'd1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b0;
                                r_grant <= '0;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_grant <= '0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign CONTROL   = r_ctrl;
    assign VALID     = r_valid;
    assign GRANT     = r_grant;
    assign ERR_FORCE = r_err;

endmodule

// File: tb/tb_arbitro_mux_forzado.sv
// Directed, table-driven bench for arbitro_mux_forzado (default parameters).
module tb_arbitro_mux_forzado;

    logic       CLK;
    logic       RESET_L;
    logic [9:0] REQ;
    logic       FORCE_EN;
    logic [3:0] FORCE_SEL;
    logic [3:0] CONTROL;
    logic       VALID;
    logic [9:0] GRANT;
    logic       ERR_FORCE;

    arbitro_mux_forzado dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .REQ       (REQ),
        .FORCE_EN  (FORCE_EN),
        .FORCE_SEL (FORCE_SEL),
        .CONTROL   (CONTROL),
        .VALID     (VALID),
        .GRANT     (GRANT),
        .ERR_FORCE (ERR_FORCE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] req;
        logic       fe;
        logic [3:0] fs;
        logic [3:0] e_ctrl;
        logic       e_valid;
        logic [9:0] e_grant;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic [9:0] req, input logic fe, input logic [3:0] fs,
                       input logic [3:0] ec, input logic ev, input logic [9:0] eg,
                       input logic ee);
        vec_t v;
        v.req = req; v.fe = fe; v.fs = fs;
        v.e_ctrl = ec; v.e_valid = ev; v.e_grant = eg; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ec, input logic ev,
                              input logic [9:0] eg, input logic ee);
        check({tag, ".ctrl"},  32'(CONTROL),   32'(ec));
        check({tag, ".valid"}, 32'(VALID),     32'(ev));
        check({tag, ".grant"}, 32'(GRANT),     32'(eg));
        check({tag, ".err"},   32'(ERR_FORCE), 32'(ee));
    endtask

    initial begin
        // single lane held: continuous re-grant of lane 0
        for (int i = 0; i < 6; i++) add(10'h001, 0, 0, 0, 1, 10'h001, 0);
        // lanes 0 and 9: finish lane-0 burst, then 4 of lane 9, then lane 0
        add(10'h201, 0, 0, 0, 1, 10'h001, 0);
        add(10'h201, 0, 0, 0, 1, 10'h001, 0);
        for (int i = 0; i < 4; i++) add(10'h201, 0, 0, 9, 1, 10'h200, 0);
        add(10'h201, 0, 0, 0, 1, 10'h001, 0);
        // lane-3 burst pre-empted by force to lane 7, then 8, release
        add(10'h008, 0, 0, 3, 1, 10'h008, 0);
        add(10'h008, 0, 0, 3, 1, 10'h008, 0);
        add(10'h088, 1, 7, 7, 1, 10'h080, 0);
        add(10'h188, 1, 8, 8, 1, 10'h100, 0);
        add(10'h3F8, 0, 0, 8, 0, 10'h000, 0);
        add(10'h3F8, 0, 0, 4, 1, 10'h010, 0);
        // illegal forced index, then legal index, then idle and lane 5
        add(10'h3F8, 1, 12, 12, 0, 10'h000, 1);
        add(10'h3F8, 1, 9, 9, 1, 10'h200, 0);
        add(10'h000, 0, 0, 9, 0, 10'h000, 0);
        add(10'h000, 0, 0, 9, 0, 10'h000, 0);
        add(10'h020, 0, 0, 5, 1, 10'h020, 0);
        add(10'h000, 0, 0, 5, 0, 10'h000, 0);
        // lane-1 burst ends exactly as force arrives: force wins
        for (int i = 0; i < 4; i++) add(10'h002, 0, 0, 1, 1, 10'h002, 0);
        add(10'h006, 1, 2, 2, 1, 10'h004, 0);
        add(10'h006, 0, 0, 2, 0, 10'h000, 0);
        add(10'h006, 0, 0, 2, 1, 10'h004, 0);

        RESET_L = 1'b1; REQ = '0; FORCE_EN = 1'b0; FORCE_SEL = '0;
        #1 RESET_L = 1'b0;
        #1 check_outs("reset", 0, 0, 10'h000, 0);
        @(posedge CLK);
        @(negedge CLK);
        RESET_L = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            REQ = vecs[i].req; FORCE_EN = vecs[i].fe; FORCE_SEL = vecs[i].fs;
            @(posedge CLK);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].e_ctrl, vecs[i].e_valid,
                          vecs[i].e_grant, vecs[i].e_err);
            @(negedge CLK);
        end

        // asynchronous reset pulse mid-burst (lane 2 active)
        REQ = 10'h3FF; FORCE_EN = 1'b0;
        @(posedge CLK);
        #1 check("pre_rst.ctrl", 32'(CONTROL), 32'd2);
        #2 RESET_L = 1'b0;
        #1 check_outs("async_rst", 0, 0, 10'h000, 0);
        #1 RESET_L = 1'b1;
        @(posedge CLK);
        #1 check_outs("post_rst", 0, 1, 10'h001, 0);
        @(negedge CLK);

`ifdef ARB_FORCE_TIMEOUT_EN
        // forced timeout: 16 forced cycles, one error pulse, lockout, re-entry
        REQ = 10'h009; FORCE_EN = 1'b1; FORCE_SEL = 4'd0;
        for (int i = 0; i < 16; i++) begin
            @(posedge CLK);
            #1 check_outs($sformatf("to_forced%0d", i), 0, 1, 10'h001, 0);
        end
        @(posedge CLK);
        #1 check_outs("to_expire", 0, 0, 10'h000, 1);
        @(posedge CLK);
        #1 check_outs("to_locked", 3, 1, 10'h008, 0);
        @(negedge CLK);
        FORCE_EN = 1'b0;
        @(negedge CLK);
        FORCE_EN = 1'b1;
        @(posedge CLK);
        #1 check_outs("to_reenter", 0, 1, 10'h001, 0);
        @(negedge CLK);
        FORCE_EN = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
